// File: rtl/smc_serial.sv
// Serial MOSFET ranking calculator: six devices arrive one per beat, each ID/gm is
// insertion-sorted on arrival and a weighted top-3/bottom-3 sum is emitted two cycles later.
module smc_serial #(
  parameter int unsigned N_DEV = 6,
  parameter int unsigned VAL_W = 8,
  parameter int unsigned OUT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [2:0]       W,
  input  logic [2:0]       V_GS,
  input  logic [2:0]       V_DS,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_n
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned PRD_W = 10;

  typedef enum logic [1:0] {IDLE, LOAD, CALC} state_t;

  state_t           state, state_nx;
  logic [VAL_W-1:0] s      [N_DEV];
  logic [VAL_W-1:0] s_nx   [N_DEV];
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       mode_q, mode_nx;
  logic             out_valid_nx;
  logic [OUT_W-1:0] out_n_nx;

  logic [2:0]       ov;
  logic             triode;
  logic [PRD_W-1:0] w_x, d_x, o_x, id_num, gm_num;
  logic             id_sel;
  logic [VAL_W-1:0] dev_val;
  logic [VAL_W-1:0] base   [N_DEV];
  logic [VAL_W-1:0] ins    [N_DEV];
  logic [N_DEV-1:0] ge;
  logic [VAL_W-1:0] sel_a, sel_b, sel_c;

  // Per-device ID/gm for the beat currently on the inputs
  always_comb begin
    ov     = (V_GS == 3'd0) ? 3'd0 : V_GS - 3'd1;
    triode = ov > V_DS;
    w_x    = PRD_W'(W);
    d_x    = PRD_W'(V_DS);
    o_x    = PRD_W'(ov);
    if (triode) begin
      id_num = w_x * d_x * (PRD_W'(2) * o_x - d_x);
      gm_num = PRD_W'(2) * w_x * d_x;
    end else begin
      id_num = w_x * o_x * o_x;
      gm_num = PRD_W'(2) * w_x * o_x;
    end
    id_sel  = (state == IDLE) ? mode[0] : mode_q[0];
    dev_val = VAL_W'((id_sel ? id_num : gm_num) / PRD_W'(3));
  end

  // Single-cycle insertion; beat 0 inserts into a cleared array so frames never mix
  always_comb begin
    for (int i = 0; i < N_DEV; i++) begin
      base[i] = (state == IDLE) ? '0 : s[i];
      ge[i]   = base[i] >= dev_val;
    end
    ins[0] = ge[0] ? base[0] : dev_val;
    for (int i = 1; i < N_DEV; i++) begin
      ins[i] = ge[i] ? base[i] : (ge[i-1] ? dev_val : base[i-1]);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_q    <= '0;
      out_valid <= 1'b0;
      out_n     <= '0;
      for (int i = 0; i < N_DEV; i++) s[i] <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      mode_q    <= mode_nx;
      out_valid <= out_valid_nx;
      out_n     <= out_n_nx;
      for (int i = 0; i < N_DEV; i++) s[i] <= s_nx[i];
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = LOAD;
      LOAD: begin
        if (!in_valid)                           state_nx = IDLE;
        else if (cnt == CNT_W'(N_DEV - 1))       state_nx = CALC;
      end
      CALC:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    for (int i = 0; i < N_DEV; i++) s_nx[i] = s[i];
    cnt_nx       = cnt;
    mode_nx      = mode_q;
    out_valid_nx = 1'b0;
    out_n_nx     = '0;
    sel_a        = mode_q[1] ? s[0] : s[N_DEV-3];
    sel_b        = mode_q[1] ? s[1] : s[N_DEV-2];
    sel_c        = mode_q[1] ? s[2] : s[N_DEV-1];
    case (state)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < N_DEV; i++) s_nx[i] = ins[i];
          cnt_nx  = CNT_W'(1);
          mode_nx = mode;
        end
      end
      LOAD: begin
        if (in_valid) begin
          for (int i = 0; i < N_DEV; i++) s_nx[i] = ins[i];
          cnt_nx = cnt + CNT_W'(1);
        end else begin
          cnt_nx = '0;
        end
      end
      CALC: begin
        cnt_nx       = '0;
        out_valid_nx = 1'b1;
        if (mode_q[0]) begin
          out_n_nx = OUT_W'(3) * OUT_W'(sel_a) + OUT_W'(4) * OUT_W'(sel_b)
                   + OUT_W'(5) * OUT_W'(sel_c);
        end else begin
          out_n_nx = OUT_W'(sel_a) + OUT_W'(sel_b) + OUT_W'(sel_c);
        end
      end
      default: cnt_nx = '0;
    endcase
  end

endmodule
